// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants and FSM state encoding for the RAM access controller.
package mem_access_ctrl_pkg;

    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 32;
    localparam int MEM_DEPTH  = 1 << ADDR_W;
    localparam int CPU_ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        R_ISSUE   = 3'd1,
        R_CAPTURE = 3'd2,
        W_ISSUE   = 3'd3,
        DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// CPU-side access controller for the 512x32 synchronous RAM: one read or write at a time.
// Optional MEM_ADDR_CHECK_EN: out-of-range MAR addresses complete with addr_fault instead of wrapping.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [CPU_ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  addr_fault,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata
);

    // state     | meaning
    // IDLE      | waiting for a request
    // R_ISSUE   | ram_read high, RAM registers the word at the next edge
    // R_CAPTURE | strobes low, ram_rdata captured into cpu_rdata at the next edge
    // W_ISSUE   | ram_write high, RAM writes at the next edge
    // DONE      | one-cycle completion pulse

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                addr_oob;

`ifdef MEM_ADDR_CHECK_EN
    assign addr_oob = |cpu_addr[CPU_ADDR_W-1:ADDR_W];
`else
    // Upper MAR bits are discarded so addresses wrap modulo the RAM depth.
    logic unused_addr_hi;
    assign unused_addr_hi = ^cpu_addr[CPU_ADDR_W-1:ADDR_W];
    assign addr_oob       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_read || req_write) begin
                    if (addr_oob) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else if (req_read) begin
                        // Read wins over a simultaneous write, like the RAM itself.
                        state_d = R_ISSUE;
                        rd_d    = 1'b1;
                        addr_d  = cpu_addr[ADDR_W-1:0];
                    end else begin
                        state_d = W_ISSUE;
                        wr_d    = 1'b1;
                        addr_d  = cpu_addr[ADDR_W-1:0];
                        wdata_d = cpu_wdata;
                    end
                end
            end
            R_ISSUE:   state_d = R_CAPTURE;
            R_CAPTURE: begin
                state_d = DONE;
                done_d  = 1'b1;
                rdata_d = ram_rdata;
            end
            W_ISSUE: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign cpu_rdata  = rdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign addr_fault = fault_q;
    assign ram_read   = rd_q;
    assign ram_write  = wr_q;
    assign ram_addr   = addr_q;
    assign ram_wdata  = wdata_q;

endmodule
